apb_spi_fifo_regif: RTL and testbench

// APB3 register front-end for the SPI core with TX/RX FIFOs, width-generic data register and error reporting.

---
 rtl/spi_regif_pkg.sv | 46 ++++
 rtl/spi_sync_fifo.sv | 53 +++++
 rtl/apb_spi_fifo_regif.sv | 176 +++++++++++++++++
 tb/tb_apb_spi_fifo_regif.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regif_pkg.sv
// Shared register map, bit positions, masks and mode encoding for the APB SPI register front-end.
package spi_regif_pkg;

  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_CR2 = 3'd1;
  localparam logic [2:0] ADDR_BR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_DR  = 3'd4;
  localparam logic [2:0] ADDR_LVL = 3'd5;

  localparam int CR1_SPIE  = 7;
  localparam int CR1_SPE   = 6;
  localparam int CR1_SPTIE = 5;
  localparam int CR1_MSTR  = 4;
  localparam int CR1_CPOL  = 3;
  localparam int CR1_CPHA  = 2;
  localparam int CR1_SSOE  = 1;
  localparam int CR1_LSBFE = 0;

  localparam int CR2_TXFLUSH = 7;
  localparam int CR2_RXFLUSH = 6;
  localparam int CR2_MODFEN  = 4;
  localparam int CR2_BIDIROE = 3;
  localparam int CR2_SPISWAI = 1;
  localparam int CR2_SPC0    = 0;

  localparam int SR_SPIF  = 7;
  localparam int SR_RXOVF = 6;
  localparam int SR_SPTEF = 5;
  localparam int SR_MODF  = 4;
  localparam int SR_TXE   = 3;
  localparam int SR_RXF   = 2;

  localparam logic [7:0] CR1_RST        = 8'h04;
  localparam logic [7:0] CR2_MASK       = 8'hDB;
  // Flush bits are write-only strobes, so only these CR2 bits are stored.
  localparam logic [7:0] CR2_STORE_MASK = 8'h1B;
  localparam logic [7:0] BR_MASK        = 8'h77;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_WAIT = 2'd1,
    MODE_STOP = 2'd2
  } spi_mode_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with push/pop/flush; flush wins over a coincident push or pop.
module spi_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  // Storage, pointers and occupancy; the caller never pushes when full without a pop.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      if (push && !pop)      count_r <= count_r + CW'(1'b1);
      else if (!push && pop) count_r <= count_r - CW'(1'b1);
    end
  end

  assign count = count_r;
  assign full  = (count_r == CW'(FIFO_DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign head  = empty ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];

endmodule

// File: rtl/apb_spi_fifo_regif.sv
// APB3 register front-end for the SPI core: config registers, TX/RX FIFOs, status flags,
// low-power mode FSM and interrupt decode.
module apb_spi_fifo_regif
  import spi_regif_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [2:0]        PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              ss,
  input  logic              tip,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              mstr,
  output logic              cpol,
  output logic              cpha,
  output logic              lsbfe,
  output logic              spiswai,
  output logic [2:0]        sppr,
  output logic [2:0]        spr,
  output logic [1:0]        spi_mode,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]        cr1_r, cr2_r, br_r;
  logic              rxovf_r, modf_r;
  spi_mode_e         mode_r, mode_nxt_s;
  logic [7:0]        cr1_nxt_s, sr_s, lvl_s;
  logic [DATA_W-1:0] rdata_s;
  logic              acc_s, err_s, wr_ok_s, rd_ok_s;
  logic              cr1_wr_s, cr2_wr_s, br_wr_s, sr_wr_s, dr_wr_s, dr_rd_s;
  logic              stop_s, tx_pop_s, rx_in_s, rx_push_s, rx_pop_s, tx_flush_s, rx_flush_s;
  logic              rxovf_set_s, modf_set_s, rxovf_nxt_s, modf_nxt_s;
  logic [DATA_W-1:0] rx_head_s;
  logic [CW-1:0]     tx_count_s, rx_count_s;
  logic              tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;

  assign acc_s   = PSEL & PENABLE;
  assign wr_ok_s = acc_s & ~err_s & PWRITE;
  assign rd_ok_s = acc_s & ~err_s & ~PWRITE;

  assign cr1_wr_s = wr_ok_s & (PADDR == ADDR_CR1);
  assign cr2_wr_s = wr_ok_s & (PADDR == ADDR_CR2);
  assign br_wr_s  = wr_ok_s & (PADDR == ADDR_BR);
  assign sr_wr_s  = wr_ok_s & (PADDR == ADDR_SR);
  assign dr_wr_s  = wr_ok_s & (PADDR == ADDR_DR);
  assign dr_rd_s  = rd_ok_s & (PADDR == ADDR_DR);

  assign stop_s     = (mode_r == MODE_STOP);
  assign tx_valid   = ~tx_empty_s & cr1_r[CR1_SPE] & ~stop_s;
  assign tx_pop_s   = tx_valid & tx_ready;
  assign tx_flush_s = cr2_wr_s & PWDATA[CR2_TXFLUSH];
  assign rx_flush_s = cr2_wr_s & PWDATA[CR2_RXFLUSH];

  // A DR read on a full RX FIFO frees a slot in the same cycle, so a coincident push is kept.
  assign rx_pop_s    = dr_rd_s;
  assign rx_in_s     = rx_valid & ~stop_s;
  assign rx_push_s   = rx_in_s & (~rx_full_s | rx_pop_s);
  assign rxovf_set_s = rx_in_s & rx_full_s & ~rx_pop_s;

  assign modf_set_s  = cr1_r[CR1_MSTR] & cr2_r[CR2_MODFEN] & ~cr1_r[CR1_SSOE] & ~ss;
  assign rxovf_nxt_s = rxovf_set_s | (rxovf_r & ~(sr_wr_s & PWDATA[SR_RXOVF]));
  assign modf_nxt_s  = modf_set_s | (modf_r & ~(sr_wr_s & PWDATA[SR_MODF]));

  assign sr_s  = {~rx_empty_s, rxovf_r, ~tx_full_s, modf_r, tx_empty_s, rx_full_s, 2'b00};
  assign lvl_s = {4'(tx_count_s), 4'(rx_count_s)};

  spi_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_tx_fifo (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .push(dr_wr_s), .push_data(PWDATA), .pop(tx_pop_s), .flush(tx_flush_s),
    .head(tx_data), .count(tx_count_s), .full(tx_full_s), .empty(tx_empty_s)
  );

  spi_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_rx_fifo (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .push(rx_push_s), .push_data(rx_data), .pop(rx_pop_s), .flush(rx_flush_s),
    .head(rx_head_s), .count(rx_count_s), .full(rx_full_s), .empty(rx_empty_s)
  );

  // Address decode: error qualification and read mux.
  always_comb begin
    err_s   = 1'b0;
    rdata_s = {DATA_W{1'b0}};
    case (PADDR)
      ADDR_CR1: begin err_s = PWRITE & tip; rdata_s[7:0] = cr1_r; end
      ADDR_CR2: begin err_s = PWRITE & tip; rdata_s[7:0] = cr2_r; end
      ADDR_BR:  begin err_s = PWRITE & tip; rdata_s[7:0] = br_r;  end
      ADDR_SR:  begin err_s = 1'b0;         rdata_s[7:0] = sr_s;  end
      ADDR_DR:  begin err_s = PWRITE ? tx_full_s : rx_empty_s; rdata_s = rx_head_s; end
      ADDR_LVL: begin err_s = PWRITE;       rdata_s[7:0] = lvl_s; end
      default:  begin err_s = 1'b1;         rdata_s = {DATA_W{1'b0}}; end
    endcase
  end

  // CR1 update; the MODF hardware clear of mstr overrides a coincident CPU write.
  always_comb begin
    cr1_nxt_s = cr1_r;
    if (cr1_wr_s) cr1_nxt_s = PWDATA[7:0];
    else          cr1_nxt_s = cr1_r;
    cr1_nxt_s[CR1_MSTR] = cr1_nxt_s[CR1_MSTR] & ~modf_set_s;
  end

  // Configuration registers and sticky status flags.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cr1_r   <= CR1_RST;
      cr2_r   <= 8'h00;
      br_r    <= 8'h00;
      rxovf_r <= 1'b0;
      modf_r  <= 1'b0;
    end else begin
      cr1_r   <= cr1_nxt_s;
      rxovf_r <= rxovf_nxt_s;
      modf_r  <= modf_nxt_s;
      if (cr2_wr_s) cr2_r <= PWDATA[7:0] & CR2_MASK & CR2_STORE_MASK;
      if (br_wr_s)  br_r  <= PWDATA[7:0] & BR_MASK;
    end
  end

  // Low-power mode state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) mode_r <= MODE_RUN;
    else          mode_r <= mode_nxt_s;
  end

  // Mode transitions driven by spe and spiswai.
  always_comb begin
    mode_nxt_s = mode_r;
    case (mode_r)
      MODE_RUN: begin
        if (!cr1_r[CR1_SPE]) mode_nxt_s = MODE_WAIT;
        else                 mode_nxt_s = MODE_RUN;
      end
      MODE_WAIT: begin
        if (cr1_r[CR1_SPE])          mode_nxt_s = MODE_RUN;
        else if (cr2_r[CR2_SPISWAI]) mode_nxt_s = MODE_STOP;
        else                         mode_nxt_s = MODE_WAIT;
      end
      MODE_STOP: begin
        if (cr1_r[CR1_SPE])           mode_nxt_s = MODE_RUN;
        else if (!cr2_r[CR2_SPISWAI]) mode_nxt_s = MODE_WAIT;
        else                          mode_nxt_s = MODE_STOP;
      end
      default: mode_nxt_s = MODE_RUN;
    endcase
  end

  assign PRDATA   = rd_ok_s ? rdata_s : {DATA_W{1'b0}};
  assign PREADY   = 1'b1;
  assign PSLVERR  = acc_s & err_s;
  assign mstr     = cr1_r[CR1_MSTR];
  assign cpol     = cr1_r[CR1_CPOL];
  assign cpha     = cr1_r[CR1_CPHA];
  assign lsbfe    = cr1_r[CR1_LSBFE];
  assign spiswai  = cr2_r[CR2_SPISWAI];
  assign sppr     = br_r[6:4];
  assign spr      = br_r[2:0];
  assign spi_mode = mode_r;
  assign irq      = (cr1_r[CR1_SPIE] & (~rx_empty_s | modf_r | rxovf_r))
                  | (cr1_r[CR1_SPTIE] & ~tx_full_s);

endmodule

// File: tb/tb_apb_spi_fifo_regif.sv
// Scoreboard bench for apb_spi_fifo_regif: APB responses and TX handshakes are checked by a
// monitor against expectations queued by the directed stimulus.
module tb_apb_spi_fifo_regif;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [2:0] PADDR = 3'd0;
  logic [7:0] PWDATA = 8'h00;
  logic [7:0] PRDATA;
  logic       PREADY, PSLVERR;
  logic       ss = 1'b1, tip = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       mstr, cpol, cpha, lsbfe, spiswai;
  logic [2:0] sppr, spr;
  logic [1:0] spi_mode;
  logic       irq;

  typedef struct {
    logic [7:0] data;
    logic       err;
    string      name;
  } exp_t;

  exp_t       apb_q[$];
  logic [7:0] tx_q[$];
  exp_t       mon_e;
  logic [7:0] mon_tx;
  int         checks = 0;
  int         errors = 0;

  apb_spi_fifo_regif #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .ss(ss), .tip(tip), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .mstr(mstr), .cpol(cpol), .cpha(cpha),
    .lsbfe(lsbfe), .spiswai(spiswai), .sppr(sppr), .spr(spr), .spi_mode(spi_mode), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  // Monitor: compare every APB access phase and every TX handshake against the queues.
  always @(negedge PCLK) begin
    if (PRESETn && PSEL && PENABLE) begin
      checks++;
      if (apb_q.size() == 0) begin
        errors++;
        $display("FAIL apb_unexpected: access at addr %0d with no expectation", PADDR);
      end else begin
        mon_e = apb_q.pop_front();
        if (PRDATA !== mon_e.data || PSLVERR !== mon_e.err || PREADY !== 1'b1) begin
          errors++;
          $display("FAIL %s: got PRDATA=%02h PSLVERR=%0b PREADY=%0b, want PRDATA=%02h PSLVERR=%0b PREADY=1",
                   mon_e.name, PRDATA, PSLVERR, PREADY, mon_e.data, mon_e.err);
        end
      end
    end
    if (PRESETn && tx_valid && tx_ready) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: tx_data=%02h emitted with nothing expected", tx_data);
      end else begin
        mon_tx = tx_q.pop_front();
        if (tx_data !== mon_tx) begin
          errors++;
          $display("FAIL tx_word: got %02h want %02h", tx_data, mon_tx);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                     input logic [7:0] exp_data, input logic exp_err, input string name);
    exp_t e;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    e.data = exp_data; e.err = exp_err; e.name = name;
    apb_q.push_back(e);
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] d, input logic e, input string n);
    apb(1'b1, addr, d, 8'h00, e, n);
  endtask

  task automatic rd(input logic [2:0] addr, input logic [7:0] d, input logic e, input string n);
    apb(1'b0, addr, 8'h00, d, e, n);
  endtask

  task automatic rx_push(input logic [7:0] d);
    @(posedge PCLK); #1;
    rx_valid = 1'b1; rx_data = d;
    @(posedge PCLK); #1;
    rx_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge PCLK);
    #1;
  endtask

  logic [7:0] tx_words [4];
  logic [7:0] rx_words [5];

  initial begin
    tx_words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    rx_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // Reset state
    #12;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_prdata", 32'(PRDATA), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_mode", 32'(spi_mode), 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Register read-back and masks
    rd(3'd0, 8'h04, 1'b0, "cr1_reset");
    wr(3'd1, 8'hFF, 1'b0, "cr2_write");
    rd(3'd1, 8'h1B, 1'b0, "cr2_readback");
    wr(3'd1, 8'h00, 1'b0, "cr2_clear");
    wr(3'd2, 8'hFF, 1'b0, "br_write");
    rd(3'd2, 8'h77, 1'b0, "br_readback");
    chk("sppr", 32'(sppr), 32'd7);
    chk("spr", 32'(spr), 32'd7);

    // TX FIFO fill, overflow error, level and status
    for (int i = 0; i < 4; i++) wr(3'd4, tx_words[i], 1'b0, "dr_push");
    wr(3'd4, 8'hE5, 1'b1, "dr_push_full");
    rd(3'd5, 8'h40, 1'b0, "lvl_tx_full");
    rd(3'd3, 8'h00, 1'b0, "sr_tx_full");
    wr(3'd5, 8'h12, 1'b1, "lvl_write");
    chk("tx_valid_spe0", 32'(tx_valid), 32'd0);

    // Drain TX in order once enabled
    for (int i = 0; i < 4; i++) tx_q.push_back(tx_words[i]);
    tx_ready = 1'b1;
    wr(3'd0, 8'h44, 1'b0, "cr1_spe");
    for (int i = 0; i < 20 && tx_q.size() != 0; i++) @(posedge PCLK);
    #1;
    chk("tx_drain_left", 32'(tx_q.size()), 32'd0);
    chk("tx_valid_empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // RX fill with overflow, then pops
    for (int i = 0; i < 5; i++) rx_push(rx_words[i]);
    rd(3'd3, 8'hEC, 1'b0, "sr_rx_ovf");
    rd(3'd5, 8'h04, 1'b0, "lvl_rx_full");
    chk("irq_masked", 32'(irq), 32'd0);
    for (int i = 0; i < 4; i++) rd(3'd4, rx_words[i], 1'b0, "dr_pop");
    rd(3'd4, 8'h00, 1'b1, "dr_pop_empty");
    wr(3'd3, 8'h40, 1'b0, "sr_w1c_rxovf");
    rd(3'd3, 8'h28, 1'b0, "sr_after_w1c");

    // Error cases
    tip = 1'b1;
    wr(3'd0, 8'hFF, 1'b1, "cr1_write_tip");
    rd(3'd0, 8'h44, 1'b0, "cr1_unchanged");
    tip = 1'b0;
    rd(3'd6, 8'h00, 1'b1, "unmapped_read");
    wr(3'd7, 8'h55, 1'b1, "unmapped_write");

    // Mode fault
    wr(3'd1, 8'h10, 1'b0, "cr2_modfen");
    wr(3'd0, 8'h54, 1'b0, "cr1_mstr");
    chk("mstr_set", 32'(mstr), 32'd1);
    ss = 1'b0;
    cycles(2);
    ss = 1'b1;
    chk("mstr_cleared", 32'(mstr), 32'd0);
    rd(3'd3, 8'h38, 1'b0, "sr_modf");
    wr(3'd0, 8'hC4, 1'b0, "cr1_spie");
    chk("irq_modf", 32'(irq), 32'd1);
    wr(3'd3, 8'h10, 1'b0, "sr_w1c_modf");
    chk("irq_cleared", 32'(irq), 32'd0);

    // Low-power modes
    wr(3'd0, 8'h04, 1'b0, "cr1_spe_off");
    cycles(2);
    chk("mode_wait", 32'(spi_mode), 32'd1);
    wr(3'd1, 8'h02, 1'b0, "cr2_spiswai");
    cycles(2);
    chk("mode_stop", 32'(spi_mode), 32'd2);
    rx_push(8'h66);
    rd(3'd5, 8'h00, 1'b0, "lvl_stop_rx");
    rd(3'd3, 8'h28, 1'b0, "sr_stop_no_ovf");
    wr(3'd4, 8'h77, 1'b0, "dr_push_stop");
    rd(3'd5, 8'h10, 1'b0, "lvl_stop_tx");
    chk("tx_valid_stop", 32'(tx_valid), 32'd0);
    wr(3'd0, 8'h44, 1'b0, "cr1_spe_on");
    cycles(2);
    chk("mode_run", 32'(spi_mode), 32'd0);
    chk("tx_valid_run", 32'(tx_valid), 32'd1);
    chk("tx_head_run", 32'(tx_data), 32'h77);
    rx_push(8'h99);
    rd(3'd5, 8'h11, 1'b0, "lvl_both");

    // Asynchronous reset with data in both FIFOs
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #2;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_mode", 32'(spi_mode), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    rd(3'd5, 8'h00, 1'b0, "lvl_after_rst");
    rd(3'd3, 8'h28, 1'b0, "sr_after_rst");
    rd(3'd0, 8'h04, 1'b0, "cr1_after_rst");

    cycles(2);
    chk("apb_pending", 32'(apb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
